// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage conditional branch resolver with operand-stall,
// redirect handshake and link-register write for BLTZAL/BGEZAL.
// Optional statistics counters (br_cnt, br_taken_cnt) are built only when
// the macro BRANCH_STAT_EN is defined.
module branch_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        branchD,
   input  logic [5:0]  opD,
   input  logic [4:0]  rtD,
   input  logic [31:0] srca,
   input  logic [31:0] srcb,
   input  logic        srca_busy,
   input  logic        srcb_busy,
   input  logic [31:0] pcD,
   input  logic [31:0] immD,
   input  logic        redirect_ready,
   input  logic        flush,
   output logic        stallD,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        link_wen,
   output logic [31:0] link_pc
`ifdef BRANCH_STAT_EN
   ,
   output logic [31:0] br_cnt,
   output logic [31:0] br_taken_cnt
`endif
);

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_OPND,
      PEND
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] target_q;

   logic        is_beq;
   logic        is_bne;
   logic        is_blez;
   logic        is_bgtz;
   logic        is_bltz;
   logic        is_bgez;
   logic        is_link;
   logic        a_zero;
   logic        taken;
   logic        opnd_busy;
   logic [31:0] target;

   logic        stall_c;
   logic        rv_c;
   logic [31:0] rpc_c;
   logic        lw_c;
   logic        resolve;
   logic        latch_tgt;

   assign is_beq  = (opD == OP_BEQ);
   assign is_bne  = (opD == OP_BNE);
   assign is_blez = (opD == OP_BLEZ);
   assign is_bgtz = (opD == OP_BGTZ);
   assign is_bltz = (opD == OP_REGIMM) && ((rtD == RT_BLTZ) || (rtD == RT_BLTZAL));
   assign is_bgez = (opD == OP_REGIMM) && ((rtD == RT_BGEZ) || (rtD == RT_BGEZAL));
   assign is_link = (opD == OP_REGIMM) && ((rtD == RT_BLTZAL) || (rtD == RT_BGEZAL));

   assign a_zero  = (srca == 32'd0);

   assign taken = (is_beq  && (srca == srcb))
               || (is_bne  && (srca != srcb))
               || (is_blez && (srca[31] || a_zero))
               || (is_bgtz && !srca[31] && !a_zero)
               || (is_bltz && srca[31])
               || (is_bgez && !srca[31]);

   // srcb only matters for the two-operand compares; srca is always consumed
   assign opnd_busy = srca_busy || ((is_beq || is_bne) && srcb_busy);

   assign target = pcD + 32'd4 + (immD << 2);

   // State register and latched redirect target
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         target_q <= 32'd0;
      end else begin
         state <= state_nxt;
         if (latch_tgt) begin
            target_q <= target;
         end
      end
   end

   // Next-state and raw output decode; flush overrides everything last
   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      rv_c      = 1'b0;
      rpc_c     = 32'd0;
      lw_c      = 1'b0;
      resolve   = 1'b0;
      latch_tgt = 1'b0;
      case (state)
         IDLE, WAIT_OPND: begin
            if (!branchD) begin
               state_nxt = IDLE;
            end else if (opnd_busy) begin
               stall_c   = 1'b1;
               state_nxt = WAIT_OPND;
            end else begin
               resolve   = 1'b1;
               lw_c      = is_link;
               state_nxt = IDLE;
               if (taken) begin
                  rv_c  = 1'b1;
                  rpc_c = target;
                  if (!redirect_ready) begin
                     latch_tgt = 1'b1;
                     state_nxt = PEND;
                  end
               end
            end
         end
         PEND: begin
            rv_c    = 1'b1;
            rpc_c   = target_q;
            stall_c = branchD;
            if (redirect_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (flush) begin
         state_nxt = IDLE;
         stall_c   = 1'b0;
         rv_c      = 1'b0;
         rpc_c     = 32'd0;
         lw_c      = 1'b0;
         resolve   = 1'b0;
         latch_tgt = 1'b0;
      end
   end

   assign stallD         = resetn && stall_c;
   assign redirect_valid = resetn && rv_c;
   assign redirect_pc    = resetn ? rpc_c : 32'd0;
   assign link_wen       = resetn && lw_c;
   assign link_pc        = resetn ? (pcD + 32'd8) : 32'd0;

`ifdef BRANCH_STAT_EN
   logic [31:0] cnt_q;
   logic [31:0] taken_cnt_q;

   // Count every resolved branch and every taken one; flush already masks resolve
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q       <= 32'd0;
         taken_cnt_q <= 32'd0;
      end else if (resolve) begin
         cnt_q <= cnt_q + 32'd1;
         if (taken) begin
            taken_cnt_q <= taken_cnt_q + 32'd1;
         end
      end
   end

   assign br_cnt       = resetn ? cnt_q : 32'd0;
   assign br_taken_cnt = resetn ? taken_cnt_q : 32'd0;
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  synchronous active-low reset.
- branchD  in  1  ID-stage instruction is a conditional branch.
- opD  in  6  ID opcode.
- rtD  in  5  ID rt field, the REGIMM selector.
- srca, srcb  in  32  forwarded rs/rt operands.
- srca_busy, srcb_busy  in  1  operand not yet available, e.g. load in EX/MEM.
- pcD  in  32  PC of the branch.
- immD  in  32  sign-extended 16-bit offset.
- redirect_ready  in  1  fetch unit accepts a redirect this cycle.
- flush  in  1  exception/ERET flush.
- stallD  out  1  hold IF/ID.
- redirect_valid  out  1  PC redirect request.
- redirect_pc  out  32  redirect target.
- link_wen  out  1  write link register, one cycle.
- link_pc  out  32  pcD+8.

Function
REQ-003 Decode SHALL use these encodings.
- BEQ 000100: taken if a==b.
- BNE 000101: taken if a!=b.
- BLEZ 000110: taken if a[31] or a==0.
- BGTZ 000111: taken if !a[31] and a!=0.
- REGIMM 000001 with rt BLTZ 00000 or BLTZAL 10000: taken if a[31].
- REGIMM 000001 with rt BGEZ 00001 or BGEZAL 10001: taken if !a[31].
- Any other op/rt: never taken, never link.
REQ-004 Target SHALL be pcD+4+(immD<<2), 32-bit modulo arithmetic, wrap-around ignored.
REQ-005 The FSM SHALL have states IDLE, WAIT_OPND, PEND; the state register is the only control state.
REQ-006 Operand need: srcb is needed only for BEQ/BNE; srca is always needed.
REQ-007 IDLE, branchD=1, a needed operand busy: go to WAIT_OPND, stallD=1, no redirect.
REQ-008 IDLE or WAIT_OPND, branchD=1, operands ready: resolve combinationally in the same cycle, stallD=0.
- Taken and redirect_ready=1: redirect_valid=1, redirect_pc=target, next state IDLE.
- Taken and redirect_ready=0: latch target, next state PEND.
- Not taken: no redirect, next state IDLE.
REQ-009 WAIT_OPND SHALL hold stallD=1 while any needed operand is busy.
REQ-010 If branchD drops in WAIT_OPND (e.g. external flush of ID), the FSM SHALL return to IDLE.
REQ-011 PEND SHALL drive redirect_valid=1 and redirect_pc=latched target until a cycle with redirect_ready=1, then return to IDLE; the latched target SHALL not change in PEND.
REQ-012 In PEND the branch has left ID.
- branchD=1 (branch in delay slot, architecturally undefined): stallD=1, that branch is not evaluated until IDLE.
- branchD=0: stallD=0.
REQ-013 link_wen SHALL pulse for one cycle, in the resolution cycle of BLTZAL/BGEZAL, regardless of taken; link_pc=pcD+8 in that cycle.
REQ-014 Each branch SHALL be resolved exactly once; a stalled branch SHALL not produce a second redirect or link.
REQ-015 flush=1 SHALL force next state IDLE and suppress redirect_valid, link_wen and stallD in that cycle; flush has priority over all but reset.

Reset
REQ-016 resetn=0 at a clock edge SHALL set state IDLE, latched target 0 and all statistic counters 0.
REQ-017 During reset all outputs SHALL be 0; reset mid-WAIT_OPND or mid-PEND SHALL drop the request with no redirect.

Configuration
REQ-018 Macro BRANCH_STAT_EN SHALL gate the statistics feature.
- Defined: adds outputs br_cnt[31:0] and br_taken_cnt[31:0], each +1 per resolved branch / per taken branch.
- The counters wrap modulo 2^32, are not incremented on a flush cycle, and are cleared by reset.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-019 The bench SHALL cover these scenarios.
- BEQ, srca=srcb=5, pcD=0x1000, immD=4, ready=1 -> same cycle redirect_valid=1, redirect_pc=0x1014, stallD=0.
- BNE, srca=srcb=7 -> no redirect, state IDLE; BGTZ with srca=0 -> not taken; BLEZ with srca=0x80000000 -> taken.
- BGEZAL, srca=0, srca_busy=1 for 3 cycles -> stallD=1 for 3 cycles, then one-cycle redirect plus link_wen with link_pc=pcD+8.
- BLTZ taken, redirect_ready=0 for 4 cycles -> redirect_valid held 5 cycles with constant pc, single acceptance, then IDLE.
- flush in PEND -> redirect_valid=0 next cycle, IDLE.
- resetn=0 mid-WAIT_OPND -> all outputs 0.
- With BRANCH_STAT_EN: 3 branches, 2 taken -> br_cnt=3, br_taken_cnt=2.
